// File: rtl/clock_display_scan.sv
// -----------------------------------------------------------------------------
// clock_display_scan
//
// Drives a 4-digit multiplexed 7-segment display as HH:MM from the packed BCD
// time-of-day counter. One digit is lit at a time. Each digit slot lasts
// SCAN_DIV clock cycles. The first GUARD cycles of every slot keep all digit
// enables off, so the previous digit's segment pattern never ghosts onto the
// next digit.
//
// The time is captured once per frame, at the end of digit 3. A frame is
// therefore never torn between two different times. The hour-tens digit is
// blanked when it is zero. The colon (dp of digit 1) toggles on every
// sec_tick. The PM indicator is the dp of digit 3.
//
// Optional build macro: CLOCK_DISPLAY_DIM_EN
//   When it is defined, the block has an extra input bright[1:0]. The slot is
//   split into four phases (the top two bits of the scan counter). A digit is
//   enabled only in phases <= bright. bright=3 gives full duty; bright=0 gives
//   roughly 1/4 duty. When the macro is undefined, duty is always full.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (power of 2, >= 8)
//   GUARD     blanked cycles at the start of each slot (< SCAN_DIV/4)
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   hh        BCD hours   {tens[2:0], units[3:0]}
//   mm        BCD minutes {tens[3:0], units[3:0]}
//   pm        1 = PM
//   sec_tick  single-cycle pulse once per second
//   bright    (CLOCK_DISPLAY_DIM_EN only) brightness level 0..3
//   seg       segments {g,f,e,d,c,b,a}, active high, registered
//   dp        decimal point of the active digit, active high, registered
//   dig       one-hot digit enable, dig[0] = hour tens, registered
// -----------------------------------------------------------------------------
module clock_display_scan #(
    parameter int SCAN_DIV = 1024,
    parameter int GUARD    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] hh,
    input  logic [7:0] mm,
    input  logic       pm,
    input  logic       sec_tick,
`ifdef CLOCK_DISPLAY_DIM_EN
    input  logic [1:0] bright,
`endif
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] dig
);

    localparam int            CW      = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    // BCD nibble to segment pattern; any non-decimal nibble shows a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    logic [CW-1:0] scan_cnt_r;
    logic [1:0]    idx_r;
    logic [6:0]    hh_q_r;
    logic [7:0]    mm_q_r;
    logic          pm_q_r;
    logic          colon_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic [3:0]    dig_r;

    logic          wrap_s;
    logic          snap_s;
    logic          slot_start_s;
    logic [3:0]    nib_s;
    logic          blank_s;
    logic [6:0]    seg_next_s;
    logic          dp_next_s;
    logic          on_s;
    logic          lit_s;
    logic [3:0]    dig_next_s;

    assign wrap_s       = (scan_cnt_r == CNT_MAX);
    assign snap_s       = wrap_s && (idx_r == 2'd3);
    assign slot_start_s = (scan_cnt_r == CNT_ZERO);

    assign seg = seg_r;
    assign dp  = dp_r;
    assign dig = dig_r;

    // Slot timer and digit index; SCAN_DIV is a power of two, so the counter wraps by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= CNT_ZERO;
            idx_r      <= 2'd0;
        end else begin
            scan_cnt_r <= scan_cnt_r + CNT_ONE;
            if (wrap_s) begin
                idx_r <= idx_r + 2'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Frame snapshot: the time is captured only as digit 3 ends, so a frame never mixes two times.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hh_q_r <= 7'h12;
            mm_q_r <= 8'h00;
            pm_q_r <= 1'b0;
        end else if (snap_s) begin
            hh_q_r <= hh;
            mm_q_r <= mm;
            pm_q_r <= pm;
        end else begin
            hh_q_r <= hh_q_r;
            mm_q_r <= mm_q_r;
            pm_q_r <= pm_q_r;
        end
    end

    // Colon blink state; this is independent of the snapshot, so both can act on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colon_r <= 1'b1;
        end else if (sec_tick) begin
            colon_r <= ~colon_r;
        end else begin
            colon_r <= colon_r;
        end
    end

    // Digit source selection, hour-tens blanking and decimal-point routing.
    always_comb begin
        nib_s      = 4'd0;
        blank_s    = 1'b0;
        dp_next_s  = 1'b0;
        seg_next_s = 7'h00;
        case (idx_r)
            2'd0: begin
                nib_s   = {1'b0, hh_q_r[6:4]};
                blank_s = (hh_q_r[6:4] == 3'd0);
            end
            2'd1: begin
                nib_s     = hh_q_r[3:0];
                dp_next_s = colon_r;
            end
            2'd2: begin
                nib_s = mm_q_r[7:4];
            end
            2'd3: begin
                nib_s     = mm_q_r[3:0];
                dp_next_s = pm_q_r;
            end
            default: begin
                nib_s     = 4'd0;
                dp_next_s = 1'b0;
            end
        endcase
        if (blank_s) begin
            seg_next_s = 7'h00;
        end else begin
            seg_next_s = bcd_to_seg(nib_s);
        end
    end

    // Digit enable: off during the guard, then one-hot (optionally gated by the brightness phase).
    always_comb begin
        on_s       = (scan_cnt_r >= GUARD_C);
        lit_s      = 1'b0;
        dig_next_s = 4'b0000;
`ifdef CLOCK_DISPLAY_DIM_EN
        lit_s = on_s && (scan_cnt_r[CW-1:CW-2] <= bright);
`else
        lit_s = on_s;
`endif
        if (lit_s) begin
            dig_next_s = 4'b0001 << idx_r;
        end else begin
            dig_next_s = 4'b0000;
        end
    end

    // Output registers: segments and dp latch once per slot; the enable follows the counter every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= 7'h00;
            dp_r  <= 1'b0;
            dig_r <= 4'b0000;
        end else begin
            if (slot_start_s) begin
                seg_r <= seg_next_s;
                dp_r  <= dp_next_s;
            end else begin
                seg_r <= seg_r;
                dp_r  <= dp_r;
            end
            dig_r <= dig_next_s;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// -----------------------------------------------------------------------------
// Testbench for clock_display_scan. A frame-position model predicts seg/dp/dig
// for every clock edge. Each prediction is queued when the inputs for that
// edge are driven, then popped and compared once the DUT output has settled.
// Directed constant checks cover the reset frame, snapshot timing, colon
// blinking, the invalid-BCD dash, guard length, async reset and, when
// CLOCK_DISPLAY_DIM_EN is defined, dimming.
// -----------------------------------------------------------------------------
module tb_clock_display_scan;

`ifdef CLOCK_DISPLAY_DIM_EN
    localparam int SD = 16;
`else
    localparam int SD = 8;
`endif
    localparam int GD = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] hh;
    logic [7:0] mm;
    logic       pm;
    logic       sec_tick;
    logic [1:0] bright_v;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hh       (hh),
        .mm       (mm),
        .pm       (pm),
        .sec_tick (sec_tick),
`ifdef CLOCK_DISPLAY_DIM_EN
        .bright   (bright_v),
`endif
        .seg      (seg),
        .dp       (dp),
        .dig      (dig)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
    } out_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int         m_pos;
    logic [6:0] m_hh;
    logic [7:0] m_mm;
    logic       m_pm;
    logic       m_colon;
    logic [6:0] m_seg;
    logic       m_dp;
    int         last_pos;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] tab [0:9];
        tab[0] = 7'h3F; tab[1] = 7'h06; tab[2] = 7'h5B; tab[3] = 7'h4F; tab[4] = 7'h66;
        tab[5] = 7'h6D; tab[6] = 7'h7D; tab[7] = 7'h07; tab[8] = 7'h7F; tab[9] = 7'h6F;
        if (n > 4'd9) return 7'h40;
        return tab[n];
    endfunction

    task automatic model_reset();
        m_pos    = 0;
        m_hh     = 7'h12;
        m_mm     = 8'h00;
        m_pm     = 1'b0;
        m_colon  = 1'b1;
        m_seg    = 7'h00;
        m_dp     = 1'b0;
        last_pos = -1;
        exp_q.delete();
    endtask

    // Predict the outputs produced by the coming edge, then advance the model past it.
    task automatic model_push();
        int   slot;
        int   c;
        out_t e;
        slot = m_pos / SD;
        c    = m_pos % SD;
        if (c == 0) begin
            case (slot)
                0: begin m_seg = (m_hh[6:4] == 3'd0) ? 7'h00 : ref_seg({1'b0, m_hh[6:4]}); m_dp = 1'b0; end
                1: begin m_seg = ref_seg(m_hh[3:0]); m_dp = m_colon; end
                2: begin m_seg = ref_seg(m_mm[7:4]); m_dp = 1'b0; end
                default: begin m_seg = ref_seg(m_mm[3:0]); m_dp = m_pm; end
            endcase
        end
        e.seg = m_seg;
        e.dp  = m_dp;
        if (c >= GD && (c / (SD / 4)) <= int'(bright_v)) e.dig = 4'(1 << slot);
        else e.dig = 4'b0000;
        exp_q.push_back(e);
        last_pos = m_pos;
        if (sec_tick) m_colon = ~m_colon;
        if (m_pos == 4 * SD - 1) begin
            m_hh = hh;
            m_mm = mm;
            m_pm = pm;
        end
        m_pos = (m_pos + 1) % (4 * SD);
    endtask

    task automatic tick();
        out_t e;
        model_push();
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("sb_seg", 32'(seg), 32'(e.seg));
            check_val("sb_dp", 32'(dp), 32'(e.dp));
            check_val("sb_dig", 32'(dig), 32'(e.dig));
        end
        check_val("dig_onehot", 32'($countones(dig) <= 1), 32'd1);
    endtask

    task automatic run_until(input int pos);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (last_pos != pos && n < 8 * SD);
        check_val("reach_pos", 32'(last_pos), 32'(pos));
    endtask

    // Count enabled cycles and the first enabled offset over the next full slot.
    task automatic count_slot(output int on_cnt, output int first_on);
        on_cnt   = 0;
        first_on = -1;
        for (int i = 0; i < SD; i++) begin
            tick();
            if (dig != 4'b0000) begin
                on_cnt++;
                if (first_on < 0) first_on = last_pos % SD;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int on_cnt;
        int first_on;
        rst_n    = 1'b0;
        hh       = 7'h12;
        mm       = 8'h00;
        pm       = 1'b0;
        sec_tick = 1'b0;
        bright_v = 2'd3;
        repeat (3) @(negedge clk);
        check_val("rst_seg", 32'(seg), 32'h00);
        check_val("rst_dp", 32'(dp), 32'h0);
        check_val("rst_dig", 32'(dig), 32'h0);

        // Reset frame shows 12:00 with the colon on
        model_reset();
        rst_n = 1'b1;
        tick();
        check_val("first_dig", 32'(dig), 32'h0);
        check_val("d0_seg", 32'(seg), 32'h06);
        tick();
        check_val("d0_dig", 32'(dig), 32'h1);
        run_until(SD);
        check_val("d1_seg", 32'(seg), 32'h5B);
        check_val("d1_dp", 32'(dp), 32'h1);

        // Snapshot timing: new time applied mid digit-1 slot
        run_until(SD + 3);
        hh = 7'h09; mm = 8'h45; pm = 1'b1;
        run_until(2 * SD);
        check_val("old_d2_seg", 32'(seg), 32'h3F);
        run_until(3 * SD);
        check_val("old_d3_seg", 32'(seg), 32'h3F);
        check_val("old_d3_dp", 32'(dp), 32'h0);
        run_until(0);
        check_val("blank_d0", 32'(seg), 32'h00);
        run_until(SD);
        check_val("new_d1_seg", 32'(seg), 32'h6F);
        check_val("new_d1_dp", 32'(dp), 32'h1);
        run_until(2 * SD);
        check_val("new_d2_seg", 32'(seg), 32'h66);
        run_until(3 * SD);
        check_val("new_d3_seg", 32'(seg), 32'h6D);
        check_val("pm_dp", 32'(dp), 32'h1);

        // Colon toggles
        sec_tick = 1'b1; tick(); sec_tick = 1'b0;
        run_until(SD);
        check_val("colon_off", 32'(dp), 32'h0);
        sec_tick = 1'b1; tick(); sec_tick = 1'b0;
        run_until(SD);
        check_val("colon_on", 32'(dp), 32'h1);

        // sec_tick on the snapshot cycle, plus an out-of-range hour and an invalid minute nibble
        run_until(4 * SD - 2);
        sec_tick = 1'b1; hh = 7'h13; mm = 8'hA3;
        tick();
        sec_tick = 1'b0;
        run_until(0);
        check_val("h13_d0", 32'(seg), 32'h06);
        run_until(SD);
        check_val("h13_d1", 32'(seg), 32'h4F);
        check_val("snap_colon", 32'(dp), 32'h0);
        run_until(2 * SD);
        check_val("dash_d2", 32'(seg), 32'h40);
        run_until(3 * SD);
        check_val("a3_d3", 32'(seg), 32'h4F);

        // Guard length over the digit-2 slot
        run_until(2 * SD - 1);
        count_slot(on_cnt, first_on);
        check_val("guard_on_cnt", 32'(on_cnt), 32'(SD - GD));
        check_val("guard_first", 32'(first_on), 32'(GD));

        // Asynchronous reset mid-slot, with no clock edge involved
        run_until(2 * SD + 4);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_dig", 32'(dig), 32'h0);
        check_val("async_seg", 32'(seg), 32'h00);
        check_val("async_dp", 32'(dp), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("rerst_d0", 32'(seg), 32'h06);
        run_until(SD);
        check_val("rerst_d1", 32'(seg), 32'h5B);
        check_val("rerst_colon", 32'(dp), 32'h1);

`ifdef CLOCK_DISPLAY_DIM_EN
        // Dimming: bright=0 lights cycles 1..3; bright=3 lights cycles 1..SD-1
        bright_v = 2'd0;
        run_until(2 * SD - 1);
        count_slot(on_cnt, first_on);
        check_val("dim0_cnt", 32'(on_cnt), 32'd3);
        check_val("dim0_first", 32'(first_on), 32'd1);
        bright_v = 2'd3;
        run_until(2 * SD - 1);
        count_slot(on_cnt, first_on);
        check_val("dim3_cnt", 32'(on_cnt), 32'd15);
        check_val("dim3_first", 32'(first_on), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
